// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift arbiter: FSM state encoding and
// shift-direction constants.
package shift_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the client blocks and the shift arbiter.
//   req_valid/req_ready  per-requester handshake (NREQ bits)
//   req_data             operands, requester i at [i*W +: W]
//   req_shift            shift amounts, requester i at [i*SW +: SW]
//   req_dir              0 = left, 1 = right
//   req_rot              per-requester rotate select (only with SHIFT_ARB_ROTATE_EN)
//   rsp_valid/rsp_ready  single response handshake
//   rsp_id/rsp_data      owner index and shifted result
// Modports: master = client side, slave = arbiter side.
interface shift_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int SW   = 2
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*W-1:0]  req_data;
    logic [NREQ*SW-1:0] req_shift;
    logic [NREQ-1:0]    req_dir;
`ifdef SHIFT_ARB_ROTATE_EN
    logic [NREQ-1:0]    req_rot;
`endif
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [W-1:0]       rsp_data;

    modport master (
`ifdef SHIFT_ARB_ROTATE_EN
        output req_rot,
`endif
        output req_valid, req_data, req_shift, req_dir, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
`ifdef SHIFT_ARB_ROTATE_EN
        input  req_rot,
`endif
        input  req_valid, req_data, req_shift, req_dir, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/shift_arb_core.sv
// Combinational barrel shifter shared by all requesters.
// Logical shift with zero fill; when ROT_EN is set and rot_i is high the
// bits shifted out re-enter at the opposite end instead.
//   data_i    operand (W)
//   shift_i   shift amount (SW, W == 2**SW)
//   dir_i     0 = left, 1 = right
//   rot_i     rotate select (ignored when ROT_EN = 0)
//   result_o  shifted/rotated result (W)
module shift_arb_core
    import shift_arb_pkg::*;
#(
    parameter int W      = 4,
    parameter int SW     = 2,
    parameter bit ROT_EN = 1'b0
) (
    input  logic [W-1:0]  data_i,
    input  logic [SW-1:0] shift_i,
    input  logic          dir_i,
    input  logic          rot_i,
    output logic [W-1:0]  result_o
);

    logic [W-1:0]  shl;
    logic [W-1:0]  shr;
    logic [W-1:0]  rol;
    logic [W-1:0]  ror;
    logic [SW-1:0] pos;

    always_comb begin
        shl = data_i << shift_i;
        shr = data_i >> shift_i;
        rol = '0;
        ror = '0;
        pos = '0;
        // Index arithmetic in SW bits wraps modulo W for free.
        for (int i = 0; i < W; i++) begin
            pos      = SW'(i) + shift_i;
            rol[pos] = data_i[SW'(i)];
            ror[SW'(i)] = data_i[pos];
        end
        if (ROT_EN && rot_i) begin
            result_o = (dir_i == DIR_RIGHT) ? ror : rol;
        end else begin
            result_o = (dir_i == DIR_RIGHT) ? shr : shl;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NREQ requesters.
// The granted request is shifted and registered; the result returns with
// the requester index on a single valid/ready response channel. A HOLD
// state accepting its response can grant again in the same cycle, giving
// one result per cycle back-to-back.
// Optional feature: define SHIFT_ARB_ROTATE_EN to add bus.req_rot and
// allow per-request rotate instead of zero-fill shift.
//   clk   clock, all logic on rising edge
//   rst   synchronous active-high reset
//   bus   shift_arbiter_if slave modport (request/response channels)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no result held; any valid request is granted immediately
// ST_HOLD | result held on rsp_*; regrant only when rsp_ready accepts it
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int SW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    shift_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);
`ifdef SHIFT_ARB_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    state_t         state_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_data_q;
    logic [IDW-1:0] rr_q;
    logic [IDW-1:0] rr_d;
    logic [W-1:0]   data_d;

    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;
    logic           can_accept;
    logic           grant_fire;
    logic [W-1:0]   data_sel;
    logic [SW-1:0]  shift_sel;
    logic           dir_sel;
    logic           rot_sel;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_q) + k) % NREQ);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // A grant needs an empty output slot or one being drained this cycle;
    // nothing is granted while reset is asserted.
    assign can_accept = !rst && ((state_q == ST_IDLE) || bus.rsp_ready);
    assign grant_fire = can_accept && gnt_any;

    always_comb begin
        bus.req_ready = '0;
        if (grant_fire) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    assign rr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        data_sel  = bus.req_data[int'(gnt_idx)*W +: W];
        shift_sel = bus.req_shift[int'(gnt_idx)*SW +: SW];
        dir_sel   = bus.req_dir[gnt_idx];
`ifdef SHIFT_ARB_ROTATE_EN
        rot_sel   = bus.req_rot[gnt_idx];
`else
        rot_sel   = 1'b0;
`endif
    end

    shift_arb_core #(
        .W      (W),
        .SW     (SW),
        .ROT_EN (ROT_EN)
    ) u_core (
        .data_i   (data_sel),
        .shift_i  (shift_sel),
        .dir_i    (dir_sel),
        .rot_i    (rot_sel),
        .result_o (data_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rr_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_fire) begin
                        state_q     <= ST_HOLD;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= gnt_idx;
                        rsp_data_q  <= data_d;
                        rr_q        <= rr_d;
                    end
                end
                ST_HOLD: begin
                    if (grant_fire) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= gnt_idx;
                        rsp_data_q  <= data_d;
                        rr_q        <= rr_d;
                    end else if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule
